// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory-port arbiter.
// Imported by the arbiter top and its wait timer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_FETCH = 2'd1;
    localparam logic [1:0] OWN_DATA  = 2'd2;

    localparam int DEF_AW           = 32;
    localparam int DEF_DW           = 32;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_TIMEOUT      = 15;

endpackage

// File: rtl/mem_arb_wait_timer.sv
// Counts memory wait cycles of one access.
// Flags expiry once TIMEOUT wait cycles have elapsed.
module mem_arb_wait_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT));

    // next count: clear wins, then count up until expiry
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CW{1'b0}};
        end else if (enable && !expired) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single memory port: fetch vs. load/store.
// One access in flight; all outputs are registered.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_done,
    output logic [DW-1:0] f_rdata,
    output logic          f_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [3:0]    d_be,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);

    localparam int SCW = $clog2(STARVE_LIMIT + 2);

    arb_state_e    state_q, state_d;
    logic [SCW-1:0] starve_q, starve_d;
    logic [1:0]    owner_q, owner_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic          f_done_q, f_done_d;
    logic [DW-1:0] f_rdata_q, f_rdata_d;
    logic          f_err_q, f_err_d;
    logic          d_done_q, d_done_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          d_err_q, d_err_d;

    logic          timer_clear_s;
    logic          timer_en_s;
    logic          timer_expired_s;
    logic          fetch_starved_s;
    logic          finish_s;
    logic          fin_err_s;
    logic [DW-1:0] fin_rdata_s;

    mem_arb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (timer_expired_s)
    );

    assign fetch_starved_s = f_req && (starve_q == SCW'(STARVE_LIMIT));

    // arbitration, access sequencing and completion routing
    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        owner_d       = owner_q;
        mem_en_d      = 1'b0;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        f_done_d      = 1'b0;
        f_rdata_d     = f_rdata_q;
        f_err_d       = f_err_q;
        d_done_d      = 1'b0;
        d_rdata_d     = d_rdata_q;
        d_err_d       = d_err_q;
        timer_clear_s = 1'b0;
        timer_en_s    = 1'b0;
        finish_s      = 1'b0;
        fin_err_s     = 1'b0;
        fin_rdata_s   = {DW{1'b0}};

        case (state_q)
            IDLE: begin
                if (d_req && !fetch_starved_s) begin
                    state_d       = ACCESS;
                    owner_d       = OWN_DATA;
                    mem_en_d      = 1'b1;
                    mem_we_d      = d_we;
                    mem_addr_d    = d_addr;
                    mem_wdata_d   = d_wdata;
                    mem_be_d      = d_be;
                    timer_clear_s = 1'b1;
                    if (!f_req) begin
                        starve_d = {SCW{1'b0}};
                    end else if (starve_q == SCW'(STARVE_LIMIT)) begin
                        starve_d = starve_q;
                    end else begin
                        starve_d = starve_q + {{(SCW-1){1'b0}}, 1'b1};
                    end
                end else if (f_req) begin
                    state_d       = ACCESS;
                    owner_d       = OWN_FETCH;
                    mem_en_d      = 1'b1;
                    mem_we_d      = 1'b0;
                    mem_addr_d    = f_addr;
                    mem_wdata_d   = {DW{1'b0}};
                    mem_be_d      = 4'hF;
                    timer_clear_s = 1'b1;
                    starve_d      = {SCW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // a write returns zero data; a timeout returns zero data with err
                if (mem_ready) begin
                    finish_s    = 1'b1;
                    fin_err_s   = 1'b0;
                    fin_rdata_s = mem_we_q ? {DW{1'b0}} : mem_rdata;
                end else if (timer_expired_s) begin
                    finish_s    = 1'b1;
                    fin_err_s   = 1'b1;
                    fin_rdata_s = {DW{1'b0}};
                end else begin
                    mem_en_d   = 1'b1;
                    timer_en_s = 1'b1;
                end

                if (finish_s) begin
                    state_d = RESP;
                    if (owner_q == OWN_FETCH) begin
                        f_done_d  = 1'b1;
                        f_rdata_d = fin_rdata_s;
                        f_err_d   = fin_err_s;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = fin_rdata_s;
                        d_err_d   = fin_err_s;
                    end
                end else begin
                    state_d = ACCESS;
                end
            end
            RESP: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            starve_q    <= {SCW{1'b0}};
            owner_q     <= OWN_NONE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            mem_be_q    <= 4'h0;
            f_done_q    <= 1'b0;
            f_rdata_q   <= {DW{1'b0}};
            f_err_q     <= 1'b0;
            d_done_q    <= 1'b0;
            d_rdata_q   <= {DW{1'b0}};
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            f_done_q    <= f_done_d;
            f_rdata_q   <= f_rdata_d;
            f_err_q     <= f_err_d;
            d_done_q    <= d_done_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign owner     = owner_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign f_done    = f_done_q;
    assign f_rdata   = f_rdata_q;
    assign f_err     = f_err_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, data priority, starvation,
// timeout, reset mid-access and wait-state reads.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_done;
    logic [31:0] f_rdata;
    logic        f_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [1:0]  owner;

    int tests;
    int fails;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_done    (f_done),
        .f_rdata   (f_rdata),
        .f_err     (f_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " mem_en"}, {31'd0, mem_en}, 32'd0);
        chk({tag, " owner"}, {30'd0, owner}, 32'd0);
        chk({tag, " f_done"}, {31'd0, f_done}, 32'd0);
        chk({tag, " d_done"}, {31'd0, d_done}, 32'd0);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        f_req     = 1'b0;
        f_addr    = 32'd0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'd0;
        d_wdata   = 32'd0;
        d_be      = 4'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        tick();
        tick();
        chk_quiet("reset");
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset f_rdata", f_rdata, 32'd0);
        chk("reset d_err", {31'd0, d_err}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: fetch only, zero wait
        f_req  = 1'b1;
        f_addr = 32'h0000_0100;
        tick();
        chk("t1 mem_en", {31'd0, mem_en}, 32'd1);
        chk("t1 owner", {30'd0, owner}, 32'd1);
        chk("t1 mem_addr", mem_addr, 32'h0000_0100);
        chk("t1 mem_be", {28'd0, mem_be}, 32'hF);
        chk("t1 mem_we", {31'd0, mem_we}, 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'hE3A0_0001;
        tick();
        chk("t1 f_done", {31'd0, f_done}, 32'd1);
        chk("t1 f_rdata", f_rdata, 32'hE3A0_0001);
        chk("t1 f_err", {31'd0, f_err}, 32'd0);
        chk("t1 mem_en off", {31'd0, mem_en}, 32'd0);
        chk("t1 d_done", {31'd0, d_done}, 32'd0);
        f_req     = 1'b0;
        mem_ready = 1'b0;
        tick();
        chk_quiet("t1 idle");

        // 2: simultaneous requests, data write wins
        f_req   = 1'b1;
        f_addr  = 32'h0000_0104;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0200;
        d_wdata = 32'hDEAD_BEEF;
        d_be    = 4'b0011;
        tick();
        chk("t2 owner data", {30'd0, owner}, 32'd2);
        chk("t2 mem_we", {31'd0, mem_we}, 32'd1);
        chk("t2 mem_be", {28'd0, mem_be}, 32'h3);
        chk("t2 mem_addr", mem_addr, 32'h0000_0200);
        chk("t2 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        chk("t2 d_done", {31'd0, d_done}, 32'd1);
        chk("t2 d_rdata write", d_rdata, 32'd0);
        chk("t2 f_done", {31'd0, f_done}, 32'd0);
        d_req     = 1'b0;
        mem_ready = 1'b0;
        tick();
        chk("t2 idle owner", {30'd0, owner}, 32'd0);
        tick();
        chk("t2 owner fetch", {30'd0, owner}, 32'd1);
        chk("t2 fetch addr", mem_addr, 32'h0000_0104);
        chk("t2 fetch we", {31'd0, mem_we}, 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        tick();
        chk("t2 f_done", {31'd0, f_done}, 32'd1);
        chk("t2 f_rdata", f_rdata, 32'hCAFE_0001);
        f_req     = 1'b0;
        mem_ready = 1'b0;
        tick();

        // 3: starvation, pattern D D D D F repeated twice
        f_req     = 1'b1;
        f_addr    = 32'h0000_0108;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h0000_0204;
        d_be      = 4'hF;
        mem_ready = 1'b1;
        mem_rdata = 32'h5A5A_0003;
        for (int g = 0; g < 10; g++) begin
            tick();
            chk($sformatf("t3 grant%0d owner", g), {30'd0, owner}, (g % 5 == 4) ? 32'd1 : 32'd2);
            tick();
            chk($sformatf("t3 grant%0d f_done", g), {31'd0, f_done}, (g % 5 == 4) ? 32'd1 : 32'd0);
            chk($sformatf("t3 grant%0d d_done", g), {31'd0, d_done}, (g % 5 == 4) ? 32'd0 : 32'd1);
            tick();
        end
        f_req     = 1'b0;
        d_req     = 1'b0;
        mem_ready = 1'b0;
        chk("t3 d_rdata", d_rdata, 32'h5A5A_0003);

        // 4: timeout after 16 mem_en cycles
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0300;
        tick();
        chk("t4 mem_en c0", {31'd0, mem_en}, 32'd1);
        d_req = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            chk($sformatf("t4 mem_en c%0d", i), {31'd0, mem_en}, 32'd1);
            chk($sformatf("t4 no done c%0d", i), {31'd0, d_done}, 32'd0);
        end
        tick();
        chk("t4 mem_en end", {31'd0, mem_en}, 32'd0);
        chk("t4 d_done", {31'd0, d_done}, 32'd1);
        chk("t4 d_err", {31'd0, d_err}, 32'd1);
        chk("t4 d_rdata", d_rdata, 32'd0);
        tick();
        d_req  = 1'b1;
        d_addr = 32'h0000_0304;
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        chk("t4 next d_done", {31'd0, d_done}, 32'd1);
        chk("t4 next d_err", {31'd0, d_err}, 32'd0);
        chk("t4 next d_rdata", d_rdata, 32'h0BAD_F00D);
        d_req     = 1'b0;
        mem_ready = 1'b0;
        tick();

        // 5: reset in the second ACCESS cycle
        f_req  = 1'b1;
        f_addr = 32'h0000_0400;
        tick();
        tick();
        chk("t5 in access", {31'd0, mem_en}, 32'd1);
        reset = 1'b1;
        tick();
        chk_quiet("t5 reset");
        chk("t5 mem_addr", mem_addr, 32'd0);
        chk("t5 d_rdata", d_rdata, 32'd0);
        reset = 1'b0;
        f_req = 1'b0;
        tick();
        chk_quiet("t5 after");
        f_req  = 1'b1;
        f_addr = 32'h0000_0408;
        tick();
        chk("t5 owner", {30'd0, owner}, 32'd1);
        chk("t5 addr", mem_addr, 32'h0000_0408);
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick();
        chk("t5 f_done", {31'd0, f_done}, 32'd1);
        chk("t5 f_rdata", f_rdata, 32'h1111_2222);
        chk("t5 f_err", {31'd0, f_err}, 32'd0);
        f_req     = 1'b0;
        mem_ready = 1'b0;
        tick();

        // 6: 3 wait states, request dropped mid-access
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0500;
        tick();
        chk("t6 mem_en rise", {31'd0, mem_en}, 32'd1);
        d_req = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("t6 wait%0d mem_en", i), {31'd0, mem_en}, 32'd1);
            chk($sformatf("t6 wait%0d d_done", i), {31'd0, d_done}, 32'd0);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h7777_8888;
        tick();
        chk("t6 d_done", {31'd0, d_done}, 32'd1);
        chk("t6 d_rdata", d_rdata, 32'h7777_8888);
        chk("t6 d_err", {31'd0, d_err}, 32'd0);
        mem_ready = 1'b0;
        tick();
        chk_quiet("t6 idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single 32-bit memory port of the ARMv4 core between the instruction-fetch requester (the microsequencer's fetch state) and the data requester (load/store microstates). It registers one request at a time, drives the memory bus until the memory reports ready or a timeout expires, and returns a one-cycle completion pulse with read data to the owning requester. It sits between the microcoded control path and the external memory model.

## Interface
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 4, max consecutive data grants while fetch waits
- TIMEOUT, 15, max wait cycles in ACCESS before bus error
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- f_req  in  1  fetch request, held until f_done
- f_addr  in  AW  fetch address (word read, all byte lanes)
- f_done  out  1  one-cycle fetch completion pulse
- f_rdata  out  DW  fetch read data, valid with f_done
- f_err  out  1  fetch timed out, valid with f_done
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_be  in  4  byte enables
- d_done, d_rdata, d_err  out  1/DW/1  as fetch equivalents
- mem_en  out  1  memory access active
- mem_we  out  1  memory write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_be  out  4  memory byte enables
- mem_ready  in  1  memory completes access this cycle
- mem_rdata  in  DW  memory read data, valid with mem_ready
- owner  out  2  0 none, 1 fetch, 2 data

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: d_req wins unless f_req=1 and starve_cnt=STARVE_LIMIT, then fetch wins; else f_req wins if set; else stay. On grant latch addr/we/wdata/be (fetch: we=0, be=4'hF, wdata=0), set owner, clear wait_cnt, go ACCESS.
- starve_cnt: on data grant with f_req=1, increment (saturating at STARVE_LIMIT); on data grant with f_req=0 or on fetch grant, clear.
- ACCESS: mem_en=1, mem_* driven from latched registers. mem_ready=1 -> capture mem_rdata (0 for writes), err=0, go RESP. Else wait_cnt++; wait_cnt=TIMEOUT with mem_ready=0 -> rdata=0, err=1, go RESP.
- RESP: owner's done=1 for exactly this cycle with rdata/err; mem_en=0; go IDLE. Non-owner done stays 0.
- Requesters must deassert or replace req/payload in the cycle after done; IDLE samples fresh inputs.
- Req deasserted mid-access is ignored; access completes and done still pulses.
- Reset: state IDLE, owner=0, starve_cnt=0, wait_cnt=0, all outputs 0. Reset during ACCESS abandons the access with no done pulse.

## Timing
- Grant in cycle N (IDLE); mem_en=1 from N+1.
- mem_ready in cycle M -> done/rdata at M+1 -> IDLE at M+2.
- Zero-wait access: 3 cycles request-to-next-decision; back-to-back grants every 3 cycles.
- Timeout: mem_en high for TIMEOUT+1 cycles, done with err one cycle later.
- All outputs registered; no combinational path from req or mem_ready to any output.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ACCESS, RESP), owner encodings OWN_NONE/OWN_FETCH/OWN_DATA, default parameter constants.
- One sub-module: mem_arb_wait_timer (clear, enable, expired at TIMEOUT) used in ACCESS.
- Starvation counter and FSM stay in the top.

## Test plan
- Fetch only, addr 0x100, mem_ready in 1st ACCESS cycle, mem_rdata 0xE3A00001 -> mem_en one cycle, f_done+f_rdata=0xE3A00001 next cycle, owner back to 0.
- Simultaneous f_req and d_req (d_we=1, addr 0x200, wdata 0xDEADBEEF, be 4'b0011) -> data granted first, mem_we=1 and mem_be=0011; fetch granted in the following IDLE.
- d_req held continuously with f_req held -> exactly 4 data grants, then 1 fetch grant, then data resumes; starve_cnt clears on fetch grant.
- mem_ready held low -> mem_en high 16 cycles, then d_done=1, d_err=1, d_rdata=0; next access without error.
- Reset asserted in 2nd ACCESS cycle -> next edge all outputs 0, no done pulse; fresh f_req after reset served normally.
- 3-wait-state read -> done exactly 4 cycles after mem_en rises; d_req dropped mid-access still yields d_done.
